bcd_to_binary_seq: RTL and testbench



---
 rtl/bcd_to_binary_seq_if.sv | 23 ++
 rtl/bcd_to_binary_seq.sv | 95 +++++++++
 tb/tb_bcd_to_binary_seq.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_to_binary_seq_if.sv
// Handshake bundle for the sequential BCD-to-binary converter.
// master: start/bcd_in out, status/result in. slave: the converter side.
interface bcd_to_binary_seq_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      binary_out;
    logic                  error;

    modport master (
        output start, bcd_in,
        input  busy, done, binary_out, error
    );

    modport slave (
        input  start, bcd_in,
        output busy, done, binary_out, error
    );
endinterface

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter, MSD first, acc = acc*10 + digit per clock.
// Ports: clk, rst_n (async active-low), bus (slave: start, bcd_in, busy, done,
// binary_out, error). Optional macro BCD2BIN_ERR_CHK_EN flags nibbles > 9.
module bcd_to_binary_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_to_binary_seq_if.slave  bus
);
    localparam int SW = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        CONV,
        DONE
    } state_t;

    state_t            state, nxt;
    logic [SW-1:0]     sh;
    logic [BIN_W-1:0]  acc, acc_nxt;
    logic [CW-1:0]     cnt;
    logic              bad, bad_any;
    logic [3:0]        nib;

    assign nib = sh[SW-1 -: 4];

    // acc*10 as shift-and-add; wraps modulo 2^BIN_W if undersized
    assign acc_nxt = (acc << 3) + (acc << 1) + BIN_W'(nib);

`ifdef BCD2BIN_ERR_CHK_EN
    always_comb begin
        bad_any = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sh[4*i +: 4] > 4'd9) bad_any = 1'b1;
        end
    end
`else
    assign bad_any = 1'b0;
`endif

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:  if (bus.start) nxt = CHECK;
            CHECK: nxt = CONV;
            CONV:  if (cnt == CW'(DIGITS - 1)) nxt = DONE;
            DONE:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            sh             <= '0;
            acc            <= '0;
            cnt            <= '0;
            bad            <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.binary_out <= '0;
            bus.error      <= 1'b0;
        end else begin
            state    <= nxt;
            bus.busy <= (nxt != IDLE);
            bus.done <= (nxt == DONE);
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        sh  <= bus.bcd_in;
                        acc <= '0;
                        cnt <= '0;
                        bad <= 1'b0;
                    end
                end
                CHECK: bad <= bad_any;
                CONV: begin
                    acc <= acc_nxt;
                    sh  <= sh << 4;
                    cnt <= cnt + CW'(1);
                    // result lands with the edge that enters DONE
                    if (nxt == DONE) begin
                        bus.binary_out <= bad ? '0 : acc_nxt;
                        bus.error      <= bad;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Randomised + directed bench for bcd_to_binary_seq with a queued scoreboard.
// Driver pushes model results; a monitor pops and compares on every done.
module tb_bcd_to_binary_seq;
    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_to_binary_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

    bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [BIN_W:0] sb[$];
    logic [BIN_W-1:0] last_bin = '0;
    logic last_err = 1'b0;

    // Decimal interpretation of the digit string, error-first if enabled
    function automatic logic [BIN_W:0] model(input logic [4*DIGITS-1:0] b);
        int v;
        bit bad;
        v = 0;
        bad = 0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            int d;
            d = int'(b[4*k +: 4]);
            if (d > 9) bad = 1;
            v = v * 10 + d;
        end
`ifdef BCD2BIN_ERR_CHK_EN
        if (bad) return {1'b1, {BIN_W{1'b0}}};
`endif
        return {1'b0, BIN_W'(v % (1 << BIN_W))};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation
    always @(posedge clk) begin
        #1;
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 expected=0");
            end else begin
                logic [BIN_W:0] e;
                e = sb.pop_front();
                chk("binary_out", int'(bus.binary_out), int'(e[BIN_W-1:0]));
                chk("error", int'(bus.error), int'(e[BIN_W]));
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) chk("idle_timeout", 1, 0);
    endtask

    // One conversion; optional second start pulse two edges after acceptance
    task automatic convert(input logic [4*DIGITS-1:0] v,
                           input bit second, input logic [4*DIGITS-1:0] v2);
        logic [BIN_W:0] e;
        int lat;
        bit busy_ok, hold_ok;
        wait_idle();
        e = model(v);
        bus.start = 1'b1;
        bus.bcd_in = v;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.bcd_in = $urandom();
        lat = 0;
        busy_ok = bus.busy;
        hold_ok = (bus.binary_out == last_bin) && (bus.error == last_err);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (second && i == 2) begin
                bus.start = 1'b1;
                bus.bcd_in = v2;
            end else begin
                bus.start = 1'b0;
            end
            busy_ok &= bus.busy;
            if (bus.done) begin
                lat = i;
                break;
            end
            hold_ok &= (bus.binary_out == last_bin) && (bus.error == last_err);
        end
        bus.start = 1'b0;
        // accept edge + CHECK + DIGITS CONV edges -> done after DIGITS+1 edges
        chk("latency", lat, DIGITS + 1);
        chk("busy_during", int'(busy_ok), 1);
        chk("result_hold", int'(hold_ok), 1);
        last_bin = e[BIN_W-1:0];
        last_err = e[BIN_W];
    endtask

    function automatic logic [4*DIGITS-1:0] rnd_bcd();
        logic [4*DIGITS-1:0] r;
        for (int k = 0; k < DIGITS; k++) begin
            if ($urandom_range(0, 4) == 0) r[4*k +: 4] = 4'($urandom_range(10, 15));
            else r[4*k +: 4] = 4'($urandom_range(0, 9));
        end
        return r;
    endfunction

    initial begin
        bit quiet;
        bus.start = 1'b0;
        bus.bcd_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_bin", int'(bus.binary_out), 0);
        chk("rst_err", int'(bus.error), 0);
        quiet = 1;
        repeat (5) begin
            @(posedge clk);
            #1;
            quiet &= !bus.busy && !bus.done;
        end
        chk("idle_quiet", int'(quiet), 1);

        convert(12'h000, 0, '0);
        convert(12'h999, 0, '0);
        convert(12'h255, 0, '0);
        convert(12'h012, 0, '0);
        convert(12'h1A3, 0, '0);
        convert(12'h347, 1, 12'h100);

        wait_idle();
        bus.start = 1'b1;
        bus.bcd_in = 12'h888;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_done", int'(bus.done), 0);
        chk("mid_rst_bin", int'(bus.binary_out), 0);
        chk("mid_rst_err", int'(bus.error), 0);
        last_bin = '0;
        last_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        convert(12'h042, 0, '0);

        repeat (40) convert(rnd_bcd(), 0, '0);

        repeat (10) @(posedge clk);
        #2;
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
